lc3_writeback: RTL
==================

// Module: lc3_writeback
// PURPOSE
//  Writeback stage of the LC-3 pipeline; sits directly downstream of the execute stage.
//  Consumes execute results (W_control, aluout, pcout, dr) plus memory read data.
//  Selects the writeback value and writes it into the 8x16 register file.
//  Updates the processor status register (PSR, NZP) and serves both register read
//  ports (sr1/sr2) back to the decode/execute side.
// PARAMETERS
//  DATA_W   16  register/data width
//  REG_CNT  8   number of architectural registers (index width = 3)
//  CNT_W    16  width of retired-writeback counter
// PORTS
//  clock             input   1   single clock; all state updates on rising edge
//  reset             input   1   asynchronous, active-low reset
//  enable_writeback  input   1   qualifies a writeback this cycle
//  W_control_in      input   2   value select: 0=aluout, 1=memout, 2=pcout, 3=reserved
//  aluout            input   16  ALU result from execute
//  pcout             input   16  PC-relative result from execute
//  memout            input   16  data read from memory
//  dr                input   3   destination register index
//  sr1               input   3   read-port-1 register index
//  sr2               input   3   read-port-2 register index
//  VSR1              output  16  contents of R[sr1]
//  VSR2              output  16  contents of R[sr2]
//  psr               output  3   {N,Z,P} of last written value
//  wb_count          output  16  number of committed writebacks
// BEHAVIOUR
//  - Reset (reset==0, async): R0..R7 <= 16'h0000; psr <= 3'b000; wb_count <= 0.
//    Reset asserted mid-operation aborts any pending write; first write after deassert
//    occurs on the first rising edge with reset==1.
//  - Commit condition: enable_writeback==1 && W_control_in!=2'd3.
//  - On commit, at rising edge: R[dr] <= wb_data; psr <= nzp(wb_data);
//    wb_count <= wb_count+1 (wraps 16'hFFFF -> 16'h0000, no saturation).
//  - wb_data mux: 0 -> aluout, 1 -> memout, 2 -> pcout. Pure combinational, no latch.
//  - W_control_in==3 with enable: no register write, psr and wb_count hold.
//  - enable_writeback==0: all state holds regardless of other inputs.
//  - nzp(v): v[15]==1 -> 3'b100; v==0 -> 3'b010; else -> 3'b001. Exactly one bit set
//    after first commit.
//  - Read ports: VSR1 = R[sr1], VSR2 = R[sr2], combinational from the array; sr1==sr2
//    is legal, both ports return the same value.
//  - Write latency 1 cycle: committed value visible on VSRx the cycle after the edge
//    (unless bypass below).
//  - All 8 registers are general; R0 is writable (no hard-wired zero).
// CONFIGURATION
//  - LC3_WB_BYPASS_EN defined: when a commit is in progress and sr1==dr (or sr2==dr),
//    VSR1 (VSR2) returns wb_data in the same cycle (write-through forwarding).
//  - LC3_WB_BYPASS_EN undefined: VSRx always reflect array contents; a read of dr in
//    the commit cycle returns the old value.
//  - Reserved-select or disabled cycles never forward, in either build.
// TESTING
//  - Reset: drive reset=0 -> all VSRx=0000, psr=000, wb_count=0; hold, then release.
//  - ALU write: en=1, W=0, aluout=8001, dr=3; next cycle sr1=3 -> VSR1=8001, psr=100,
//    wb_count=1.
//  - Mux select: W=1, memout=0000, dr=5 -> R5=0000, psr=010. Then W=2, pcout=0042,
//    dr=5 -> R5=0042, psr=001.
//  - Hold: en=0 or W=3 with aluout=FFFF, dr=3 -> R3, psr, wb_count unchanged.
//  - Bypass: en=1, W=0, aluout=1234, dr=2, sr1=sr2=2 in the same cycle.
//    With LC3_WB_BYPASS_EN: VSR1=VSR2=1234 in that cycle.
//    Without it: both show the old R2 value; 1234 appears the next cycle.
//  - Wrap/async reset: preload wb_count=FFFF via 65535 commits, commit once -> 0000.
//    Assert reset between clock edges -> outputs clear immediately.

Source files
------------

// File: rtl/lc3_writeback.sv
// lc3_writeback -- LC-3 writeback stage.
//   Selects the writeback value (aluout / memout / pcout) and commits it into
//   the REG_CNT x DATA_W register file. On each commit it also updates the
//   NZP status and increments a free-running (wrapping) commit counter. It
//   serves two combinational read ports back to decode/execute.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   enable_writeback      qualifies a writeback this cycle
//   W_control_in[1:0]     0=aluout 1=memout 2=pcout 3=reserved (no commit)
//   aluout/pcout/memout   candidate writeback values
//   dr, sr1, sr2          destination / read-port register indices
//   VSR1, VSR2            R[sr1], R[sr2]
//   psr[2:0]              {N,Z,P} of the last committed value
//   wb_count              number of committed writebacks (wraps)
// Configuration macro: LC3_WB_BYPASS_EN -- forward wb_data to a read port
//   whose index matches dr during a commit cycle.
module lc3_writeback #(
  parameter  int DATA_W  = 16,
  parameter  int REG_CNT = 8,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_control_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [IDX_W-1:0]  dr,
  input  logic [IDX_W-1:0]  sr1,
  input  logic [IDX_W-1:0]  sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs [REG_CNT];
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  function automatic logic [2:0] nzp(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])  return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  // Select 3 never commits, so its mux value is a don't-care; drive zero.
  always_comb begin
    wb_data = '0;
    case (W_control_in)
      2'd0:    wb_data = aluout;
      2'd1:    wb_data = memout;
      2'd2:    wb_data = pcout;
      default: wb_data = '0;
    endcase
  end

  assign commit = enable_writeback && (W_control_in != 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      psr      <= 3'b000;
      wb_count <= '0;
    end else if (commit) begin
      regs[dr] <= wb_data;
      psr      <= nzp(wb_data);
      wb_count <= wb_count + 1'b1;
    end
  end

`ifdef LC3_WB_BYPASS_EN
  // Write-through forwarding: a same-cycle reader of dr sees the new value.
  assign VSR1 = (commit && (sr1 == dr)) ? wb_data : regs[sr1];
  assign VSR2 = (commit && (sr2 == dr)) ? wb_data : regs[sr2];
`else
  assign VSR1 = regs[sr1];
  assign VSR2 = regs[sr2];
`endif

endmodule
